// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad row-scan controller: scan FSM encoding
// and the key-code width helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        DRIVE   = 2'd0,
        SAMPLE  = 2'd1,
        COMPARE = 2'd2
    } scan_state_t;

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable
// reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments let both stages sample the old value on
    // the same edge; blocking here would collapse the chain into one flop.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad controller: drives one row low at a time, builds a
// whole-matrix image, debounces it over DB_SCANS scans and emits press/release events.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SETTLE   = 3,
    parameter int DB_SCANS = 4
) (
    input  logic                              clock,
    input  logic                              reset_n,
    output logic [ROWS-1:0]                   row_n,
    input  logic [COLS-1:0]                   col_n,
    output logic                              key_valid,
    input  logic                              key_ready,
    output logic [code_width(ROWS, COLS)-1:0] key_code,
    output logic                              key_press,
    output logic                              ghost
);

    localparam int KEYS = ROWS * COLS;
    localparam int CW   = code_width(ROWS, COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int SW   = $clog2(SETTLE);
    localparam int DW   = $clog2(DB_SCANS + 1);

    logic [COLS-1:0] sync_col;
    scan_state_t     state, state_next;
    logic [RW-1:0]   row_idx, row_next;
    logic [SW-1:0]   settle_cnt, settle_next;
    logic            armed;

    logic [KEYS-1:0] image, prev_image;
    logic [DW-1:0]   stable_cnt, stable_next;
    logic            rep_valid;
    logic [CW-1:0]   rep_code;

    logic [1:0]      key_cnt;
    logic [CW-1:0]   key_idx;
    logic            qualify, ev_fire, ev_press, ghost_hit;
    logic [CW-1:0]   ev_code;

    // Only zero, one or "many" keys matter, so the count saturates at 2.
    function automatic logic [1:0] key_count(input logic [KEYS-1:0] img);
        logic [1:0] n;
        n = 2'd0;
        for (int i = 0; i < KEYS; i++) begin
            if (img[i] && n != 2'd2) n = n + 2'd1;
        end
        return n;
    endfunction

    function automatic logic [CW-1:0] key_index(input logic [KEYS-1:0] img);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (img[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    sync_2ff #(
        .WIDTH    (COLS),
        .RESET_VAL({COLS{1'b1}})
    ) u_col_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (col_n),
        .q      (sync_col)
    );

    // armed holds the scan on the edge that releases reset, so row 0 gets a
    // full settle window starting on the first cycle out of reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= DRIVE;
            row_idx    <= '0;
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            state      <= state_next;
            row_idx    <= row_next;
            settle_cnt <= settle_next;
            armed      <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        row_next    = row_idx;
        settle_next = settle_cnt;
        row_n       = '1;
        if (armed) begin
            unique case (state)
                DRIVE: begin
                    row_n = ~(ROWS'(1) << row_idx);
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        settle_next = '0;
                        state_next  = SAMPLE;
                    end else begin
                        settle_next = settle_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    row_n = ~(ROWS'(1) << row_idx);
                    if (row_idx == RW'(ROWS - 1)) begin
                        state_next = COMPARE;
                    end else begin
                        row_next   = row_idx + 1'b1;
                        state_next = DRIVE;
                    end
                end
                COMPARE: begin
                    row_next   = '0;
                    state_next = DRIVE;
                end
                default: state_next = DRIVE;
            endcase
        end
    end

    always_comb begin
        key_cnt = key_count(image);
        key_idx = key_index(image);
        if (image != prev_image)               stable_next = DW'(1);
        else if (stable_cnt == DW'(DB_SCANS))  stable_next = stable_cnt;
        else                                   stable_next = stable_cnt + 1'b1;

        // A pending event defers everything; the next COMPARE re-evaluates.
        qualify   = (state == COMPARE) && (stable_next == DW'(DB_SCANS)) && !key_valid;
        ev_fire   = 1'b0;
        ev_press  = 1'b0;
        ev_code   = rep_code;
        ghost_hit = 1'b0;
        if (qualify) begin
            unique case (key_cnt)
                2'd0: ev_fire = rep_valid;
                2'd1: begin
                    if (!rep_valid) begin
                        ev_fire  = 1'b1;
                        ev_press = 1'b1;
                        ev_code  = key_idx;
                    end else if (key_idx != rep_code) begin
                        ev_fire = 1'b1;
                    end
                end
                default: ghost_hit = 1'b1;
            endcase
        end
    end

    // NOTE: the image registers are reset like any control state because a
    // reset must discard a half-built scan rather than debounce against it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            image      <= '0;
            prev_image <= '0;
            stable_cnt <= '0;
            rep_valid  <= 1'b0;
            rep_code   <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            key_press  <= 1'b0;
            ghost      <= 1'b0;
        end else begin
            ghost <= ghost_hit;
            if (key_valid && key_ready) key_valid <= 1'b0;
            if (state == SAMPLE) image[row_idx*COLS +: COLS] <= ~sync_col;
            if (state == COMPARE) begin
                stable_cnt <= stable_next;
                if (image != prev_image) prev_image <= image;
            end
            if (ev_fire) begin
                key_valid <= 1'b1;
                key_code  <= ev_code;
                key_press <= ev_press;
                rep_valid <= ev_press;
                rep_code  <= ev_code;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a scan-level keypad model predicts
// every event, ghost pulse and row drive; a monitor compares at handshakes.
module tb_keypad_scan_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SETTLE   = 3;
    localparam int DB_SCANS = 4;
    localparam int KEYS     = ROWS * COLS;
    localparam int RP       = SETTLE + 1;
    localparam int SCAN     = ROWS * RP + 1;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_n;
    logic            key_valid;
    logic            key_ready = 1'b1;
    logic [3:0]      key_code;
    logic            key_press;
    logic            ghost;
    logic [KEYS-1:0] keys = '0;

    int checks = 0;
    int failures = 0;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DB_SCANS(DB_SCANS)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_code (key_code),
        .key_press(key_press),
        .ghost    (ghost)
    );

    always #5 clock = ~clock;

    // Passive switch matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!row_n[r] && keys[r*COLS + c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model, one step per clock: scan image rows are the key state
    // two cycles before each row is sampled; debounce rules run at scan end.
    bit              in_run = 1'b0;
    int              t = 0;
    logic [KEYS-1:0] m_img = '0, m_prev = '0;
    int              m_stab = 0;
    bit              m_rep_v = 1'b0;
    int              m_rep_k = 0;
    bit              m_valid = 1'b0, m_ghost = 1'b0;
    logic [4:0]      exp_q[$];
    logic [4:0]      acc_q[$];
    time             acc_t[$];
    int              ghost_pulses = 0;

    task automatic model_compare();
        int n, k;
        n = $countones(m_img);
        k = 0;
        for (int i = KEYS - 1; i >= 0; i--) if (m_img[i]) k = i;
        if (m_img == m_prev) begin
            if (m_stab < DB_SCANS) m_stab++;
        end else begin
            m_stab = 1;
            m_prev = m_img;
        end
        if (m_stab == DB_SCANS && !m_valid) begin
            if (n >= 2) begin
                m_ghost = 1'b1;
            end else if (n == 1 && !m_rep_v) begin
                exp_q.push_back({4'(k), 1'b1});
                m_rep_v = 1'b1;
                m_rep_k = k;
                m_valid = 1'b1;
            end else if (m_rep_v && (n == 0 || k != m_rep_k)) begin
                exp_q.push_back({4'(m_rep_k), 1'b0});
                m_rep_v = 1'b0;
                m_valid = 1'b1;
            end
        end
    endtask

    always @(posedge clock) begin : model
        int  p;
        bit  accept;
        if (!reset_n) begin
            in_run = 1'b0; t = 0; m_img = '0; m_prev = '0; m_stab = 0;
            m_rep_v = 1'b0; m_rep_k = 0; m_valid = 1'b0; m_ghost = 1'b0;
            exp_q.delete();
        end else if (!in_run) begin
            in_run = 1'b1;
            t = 0;
        end else begin
            p = t % SCAN;
            m_ghost = 1'b0;
            accept = m_valid && key_ready;
            if (p < ROWS * RP && p % RP == SETTLE - 2)
                m_img[(p / RP)*COLS +: COLS] = keys[(p / RP)*COLS +: COLS];
            if (p == SCAN - 1) model_compare();
            if (accept) m_valid = 1'b0;
            t++;
        end
    end

    always @(negedge clock) begin : monitor
        logic [ROWS-1:0] exp_row;
        logic [4:0]      ev, exp_ev;
        int              p;
        exp_row = '1;
        if (in_run) begin
            p = t % SCAN;
            if (p < ROWS * RP) exp_row = ~(4'(1) << (p / RP));
        end
        check("row_n", row_n, exp_row);
        check("key_valid", key_valid, m_valid);
        check("ghost", ghost, m_ghost);
        if (ghost) ghost_pulses++;
        if (key_valid && key_ready) begin
            ev = {key_code, key_press};
            acc_q.push_back(ev);
            acc_t.push_back($time);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got code=%0d press=%0b, expected no event at t=%0t",
                         key_code, key_press, $time);
            end else begin
                exp_ev = exp_q.pop_front();
                check("event_code", key_code, exp_ev[4:1]);
                check("event_press", key_press, exp_ev[0]);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        acc_q.delete();
        acc_t.delete();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int kind, hold;
        logic [KEYS-1:0] pat;

        // Reset hold and release: row 0 first, row 1 four cycles later, 17-cycle scan.
        cycles(4);
        @(negedge clock);
        check("row_n_in_reset", row_n, 4'b1111);
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("first_row_drive", row_n, 4'b1110);
        repeat (4) @(negedge clock);
        check("row1_drive", row_n, 4'b1101);
        repeat (12) @(negedge clock);
        check("compare_gap", row_n, 4'b1111);
        repeat (SCAN) @(negedge clock);
        check("compare_period", row_n, 4'b1111);

        // Clean press and release of key 9 (row 2, col 1).
        clear_log();
        keys = 16'(1) << 9;
        cycles(8 * SCAN);
        check("press9_count", acc_q.size(), 1);
        check("press9_event", acc_q[0], {4'd9, 1'b1});
        keys = '0;
        cycles(8 * SCAN);
        check("release9_count", acc_q.size(), 2);
        check("release9_event", acc_q[1], {4'd9, 1'b0});

        // Bouncing contact on key 6, then held steady.
        clear_log();
        for (int i = 0; i < 12; i++) begin
            keys = keys ^ (16'(1) << 6);
            cycles(5);
        end
        check("bounce_no_event", acc_q.size(), 0);
        keys = 16'(1) << 6;
        cycles(8 * SCAN);
        check("bounce_single_press", acc_q.size(), 1);
        check("bounce_press_event", acc_q[0], {4'd6, 1'b1});
        keys = '0;
        cycles(8 * SCAN);

        // Two keys together: ghost pulses, no events.
        clear_log();
        ghost_pulses = 0;
        keys = (16'(1) << 0) | (16'(1) << 5);
        cycles(8 * SCAN);
        check("ghost_no_event", acc_q.size(), 0);
        check("ghost_pulses_min3", 32'(ghost_pulses >= 3), 1);
        keys = '0;
        cycles(6 * SCAN);

        // Stalled consumer: press of 3 held, release deferred until handshake.
        clear_log();
        key_ready = 1'b0;
        keys = 16'(1) << 3;
        cycles(8 * SCAN);
        check("stall_valid", key_valid, 1);
        check("stall_code", key_code, 3);
        check("stall_press", key_press, 1);
        keys = '0;
        cycles(8 * SCAN);
        check("stall_hold_valid", key_valid, 1);
        check("stall_hold_code", key_code, 3);
        check("stall_hold_press", key_press, 1);
        key_ready = 1'b1;
        cycles(3 * SCAN);
        check("stall_event_count", acc_q.size(), 2);
        check("stall_press_event", acc_q[0], {4'd3, 1'b1});
        check("stall_release_event", acc_q[1], {4'd3, 1'b0});

        // Key 4 straight to key 7: release 4, press 7 exactly one scan later.
        clear_log();
        keys = 16'(1) << 4;
        cycles(8 * SCAN);
        keys = 16'(1) << 7;
        cycles(8 * SCAN);
        check("swap_event_count", acc_q.size(), 3);
        check("swap_press4", acc_q[0], {4'd4, 1'b1});
        check("swap_release4", acc_q[1], {4'd4, 1'b0});
        check("swap_press7", acc_q[2], {4'd7, 1'b1});
        check("swap_one_scan_gap", 32'(acc_t[2] - acc_t[1]), SCAN * 10);

        // Reset mid-scan with an event pending.
        key_ready = 1'b0;
        keys = '0;
        for (int i = 0; i < 10 * SCAN && !key_valid; i++) cycles(1);
        check("pending_before_reset", key_valid, 1);
        cycles(5);
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("reset_clears_valid", key_valid, 0);
        check("reset_restart_row0", row_n, 4'b1110);
        key_ready = 1'b1;

        // Randomized key patterns, hold times and consumer back-pressure.
        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       pat = '0;
                3:       pat = (16'(1) << $urandom_range(0, KEYS - 1)) |
                               (16'(1) << $urandom_range(0, KEYS - 1));
                default: pat = 16'(1) << $urandom_range(0, KEYS - 1);
            endcase
            keys = pat;
            hold = $urandom_range(10, 140);
            for (int c = 0; c < hold; c++) begin
                key_ready = ($urandom_range(0, 3) != 0);
                cycles(1);
            end
        end
        keys = '0;
        key_ready = 1'b1;
        cycles(10 * SCAN);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_valid_idle", key_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Row-scanning controller for a ROWS×COLS active-low key matrix. It drives one row at a time, samples the synchronized column lines, and debounces whole-matrix scan images by requiring DB_SCANS identical consecutive images. It emits press/release events on a valid/ready handshake. It sits between the board keypad pins and the user-logic event consumer.

## Interface
- ROWS, 4, number of matrix rows (≥2)
- COLS, 4, number of matrix columns (≥2)
- SETTLE, 3, cycles a row is driven before its columns are sampled (≥3, covers 2-flop sync latency)
- DB_SCANS, 4, identical consecutive scan images required for stability (≥2)
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- row_n  out  ROWS  one-hot-low row drive; reset value all ones
- col_n  in  COLS  raw column inputs, active-low, asynchronous to clock
- key_valid  out  1  event pending; reset 0
- key_ready  in  1  consumer accepts the event when key_valid && key_ready
- key_code  out  $clog2(ROWS*COLS)  row*COLS+col; reset 0
- key_press  out  1  1 = press, 0 = release; reset 0
- ghost  out  1  one-cycle pulse when a stable image has ≥2 keys; reset 0

## Operation
- col_n passes through a 2-flop synchronizer (reset 1s) before any use; the image stores inverted values (1 = pressed).
- FSM states:
  - DRIVE: row r driven low; settle counter runs 0..SETTLE-1. At SETTLE-1 → SAMPLE.
  - SAMPLE: image[r*COLS +: COLS] ← ~sync_col. If r<ROWS-1, r++ and → DRIVE; else → COMPARE.
  - COMPARE: r←0, → DRIVE.
- Reset sets r=0 and state DRIVE; row_n is all ones during reset.
- In COMPARE:
  - If image == prev_image, stable_cnt++ (saturating at DB_SCANS); otherwise stable_cnt←1 and prev_image←image.
- Event generation happens in COMPARE, only when stable_cnt (after update) == DB_SCANS and key_valid == 0. `reported` is a {valid, code} register.
  - Image has exactly one key K and reported is none: press event K; reported←K.
  - Image is empty and reported is K: release event K; reported←none.
  - Image has exactly one key J ≠ reported K: release event K; reported←none. The press of J follows at the next COMPARE.
  - Image has ≥2 keys: no event; ghost pulses; reported unchanged.
- Deferral: if key_valid is still 1 when a condition arises, no event is generated and reported is not updated. The condition is re-evaluated at every later COMPARE, so nothing is lost.
- An event loads key_code, key_press and key_valid=1. key_valid clears on the cycle after key_valid && key_ready. Outputs are held stable while valid && !ready.
- Reset mid-scan discards the image, prev_image, stable_cnt, reported and any pending event.

## Timing
- Row period = SETTLE+1 cycles; scan period = ROWS*(SETTLE+1)+1 cycles (defaults: 17).
- First row drive: the first cycle after reset_n is sampled high.
- key_valid rises the cycle after the qualifying COMPARE.
- Minimum press-to-event latency = DB_SCANS full scans after the first scan that sees the key, plus 2 sync cycles.
- ghost is high for exactly the cycle after COMPARE.
- Simultaneous key_ready and a new qualifying COMPARE in the same cycle: the new event is deferred to the next COMPARE (valid is still 1 during that evaluation).

## Structure
- Shared package `keypad_pkg`: FSM state encoding (DRIVE, SAMPLE, COMPARE) and the code-width constant function.
- One sub-module, `sync_2ff` (parameterized width, reset value), for col_n synchronization.
- Popcount and index encoding stay in this module.

## Test plan
- Reset hold, release: row_n=4'b1111 during reset; 4'b1110 on the first cycle after release. Row 1 is driven 4 cycles later. COMPARE recurs every 17 cycles.
- Hold key (row2,col1) clean: exactly one press event, key_code=9, key_press=1, after 4 stable scans. Release: one release event with code 9.
- Bounce col_n toggling every 5 cycles for 60 cycles, then steady: no event until 4 identical scans after settling; exactly one press.
- Keys 0 and 5 held together: ghost pulses once per stable COMPARE; no key_valid.
- key_ready held low after a press of key 3, key released: key_valid stays 1 with code 3/press. Assert ready: the release event for 3 appears at the next COMPARE after the handshake.
- Key 4 → key 7 without an empty scan: release 4 followed one scan later by press 7. A reset_n pulse mid-scan clears key_valid and the scan restarts at row 0.
